// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage owning the PC, one outstanding bus read, and the fetch/decode slot.
// Optional performance counters are compiled in when FETCH_PERF_EN is defined.
`default_nettype none

module fetch_stage #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [31:0] f_raw_instr,
  output logic [63:0] f_pc,
  input  logic        d_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        ireq_valid_q, ireq_valid_d;
  logic [63:0] ireq_addr_q, ireq_addr_d;
  logic        f_valid_q, f_valid_d;
  logic [31:0] f_raw_q, f_raw_d;
  logic [63:0] f_pc_q, f_pc_d;

  logic        transfer;
  logic        slot_free;
  logic [63:0] redirect_aligned;

  assign transfer         = f_valid_q && d_ready;
  assign slot_free        = !f_valid_q || d_ready;
  assign redirect_aligned = redirect_pc & ~64'd3;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ireq_valid_d = ireq_valid_q;
    ireq_addr_d  = ireq_addr_q;
    f_valid_d    = f_valid_q && !transfer;
    f_raw_d      = f_raw_q;
    f_pc_d       = f_pc_q;

    case (state_q)
      S_IDLE: begin
        if (!redirect_valid && slot_free) begin
          ireq_valid_d = 1'b1;
          ireq_addr_d  = pc_q;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          // The bus address must not move mid-transaction, so an unanswered
          // request is drained in DISCARD instead of being abandoned.
          if (iresp_data_ok) begin
            ireq_valid_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            state_d      = S_DISCARD;
          end
        end else if (iresp_data_ok) begin
          f_valid_d    = 1'b1;
          f_raw_d      = iresp_data;
          f_pc_d       = ireq_addr_q;
          pc_d         = ireq_addr_q + 64'd4;
          ireq_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (iresp_data_ok) begin
          ireq_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        ireq_valid_d = 1'b0;
      end
    endcase

    if (redirect_valid) begin
      f_valid_d = 1'b0;
      pc_d      = redirect_aligned;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_RESET;
      ireq_valid_q <= 1'b0;
      ireq_addr_q  <= 64'd0;
      f_valid_q    <= 1'b0;
      f_raw_q      <= 32'd0;
      f_pc_q       <= 64'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ireq_valid_q <= ireq_valid_d;
      ireq_addr_q  <= ireq_addr_d;
      f_valid_q    <= f_valid_d;
      f_raw_q      <= f_raw_d;
      f_pc_q       <= f_pc_d;
    end
  end

  assign ireq_valid  = ireq_valid_q;
  assign ireq_addr   = ireq_addr_q;
  assign f_valid     = f_valid_q;
  assign f_raw_instr = f_raw_q;
  assign f_pc        = f_pc_q;

`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetched_q, perf_fetched_d;
  logic [63:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (transfer) begin
      perf_fetched_d = perf_fetched_q + 64'd1;
    end
    if (f_valid_q && !d_ready) begin
      perf_stall_d = perf_stall_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_q <= 64'd0;
      perf_stall_q   <= 64'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
`default_nettype none

module tb_fetch_stage;

  localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  wire         iresp_data_ok;
  wire  [31:0] iresp_data;
  logic        f_valid;
  logic [31:0] f_raw_instr;
  logic [63:0] f_pc;
  logic        d_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  // memory responder (mem_en=1) or manual response driving (mem_en=0)
  logic        mem_en = 1'b0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        mem_ok = 1'b0;
  logic [31:0] mem_data = 32'd0;
  logic        man_ok = 1'b0;
  logic [31:0] man_data = 32'd0;

  assign iresp_data_ok = mem_en ? mem_ok : man_ok;
  assign iresp_data    = mem_en ? mem_data : man_data;

  always #5 clk = ~clk;

  fetch_stage #(.PC_RESET(PC_RST)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .f_valid       (f_valid),
    .f_raw_instr   (f_raw_instr),
    .f_pc          (f_pc),
    .d_ready       (d_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_stall    (perf_stall)
`endif
  );

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_en && ireq_valid && !mem_ok) begin
        if (mem_cnt >= mem_lat) begin
          mem_ok   = 1'b1;
          mem_data = ireq_addr[31:0];
          mem_cnt  = 0;
        end else begin
          mem_cnt = mem_cnt + 1;
        end
      end else begin
        mem_ok  = 1'b0;
        mem_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_en         = 1'b0;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    man_ok         = 1'b0;
    man_data       = 32'd0;
    d_ready        = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    mem_en         = 1'b0;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    d_ready        = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL reset_ireq_valid: got %b expected 0", ireq_valid); end
    checks++; if (ireq_addr !== 64'd0) begin errors++; $display("FAIL reset_ireq_addr: got %h expected 0", ireq_addr); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid: got %b expected 0", f_valid); end
    checks++; if (f_raw_instr !== 32'd0) begin errors++; $display("FAIL reset_f_raw_instr: got %h expected 0", f_raw_instr); end
    checks++; if (f_pc !== 64'd0) begin errors++; $display("FAIL reset_f_pc: got %h expected 0", f_pc); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_fetched !== 64'd0) begin errors++; $display("FAIL reset_perf_fetched: got %0d expected 0", perf_fetched); end
    checks++; if (perf_stall !== 64'd0) begin errors++; $display("FAIL reset_perf_stall: got %0d expected 0", perf_stall); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_fetch();
    logic [63:0] exp_pc;
    logic [31:0] exp_raw;
    bit          seen;
    mem_lat = 1;
    mem_en  = 1'b1;
    d_ready = 1'b1;
    step();
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== PC_RST) begin errors++; $display("FAIL first_request: got valid=%b addr=%h expected valid=1 addr=%h", ireq_valid, ireq_addr, PC_RST); end
    for (int i = 0; i < 3; i++) begin
      exp_pc  = PC_RST + 64'(4 * i);
      exp_raw = exp_pc[31:0];
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (f_valid) seen = 1'b1;
        else step();
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL fetch_slot_timeout[%0d]: got no f_valid expected f_valid within 20 cycles", i);
      end else if (f_pc !== exp_pc || f_raw_instr !== exp_raw) begin
        errors++; $display("FAIL fetch_slot[%0d]: got pc=%h raw=%h expected pc=%h raw=%h", i, f_pc, f_raw_instr, exp_pc, exp_raw);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (f_valid) seen = 1'b1;
      else step();
    end
    d_ready = 1'b0;
    checks++;
    if (!seen) begin
      errors++; $display("FAIL bp_slot_timeout: got no f_valid expected f_valid within 20 cycles");
    end else if (f_pc !== PC_RST + 64'd12 || f_raw_instr !== 32'h8000_000C) begin
      errors++; $display("FAIL bp_slot: got pc=%h raw=%h expected pc=%h raw=8000000c", f_pc, f_raw_instr, PC_RST + 64'd12);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (f_valid !== 1'b1 || f_pc !== PC_RST + 64'd12 || f_raw_instr !== 32'h8000_000C) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h raw=%h expected v=1 pc=%h raw=8000000c", c, f_valid, f_pc, f_raw_instr, PC_RST + 64'd12); end
      checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL bp_no_request[%0d]: got ireq_valid=%b expected 0", c, ireq_valid); end
    end
    d_ready = 1'b1;
    step();
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== PC_RST + 64'd16) begin errors++; $display("FAIL bp_resume_request: got valid=%b addr=%h expected valid=1 addr=%h", ireq_valid, ireq_addr, PC_RST + 64'd16); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL bp_resume_slot: got f_valid=%b expected 0", f_valid); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_1002;
    step();
    redirect_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (ireq_valid !== 1'b1 || ireq_addr !== PC_RST) begin errors++; $display("FAIL discard_hold[%0d]: got valid=%b addr=%h expected valid=1 addr=%h", c, ireq_valid, ireq_addr, PC_RST); end
      checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL discard_slot[%0d]: got f_valid=%b expected 0", c, f_valid); end
      if (c == 2) begin
        man_ok   = 1'b1;
        man_data = 32'hDEAD_BEEF;
      end
      step();
    end
    man_ok = 1'b0;
    checks++; if (ireq_valid !== 1'b0 || f_valid !== 1'b0) begin errors++; $display("FAIL discard_drop: got ireq_valid=%b f_valid=%b expected 0 0", ireq_valid, f_valid); end
    step();
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h0000_0000_8000_1000) begin errors++; $display("FAIL discard_next_request: got valid=%b addr=%h expected valid=1 addr=0000000080001000", ireq_valid, ireq_addr); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL discard_after_slot: got f_valid=%b expected 0", f_valid); end
  endtask

  task automatic test_redirect_dataok();
    do_reset();
    step();
    man_ok         = 1'b1;
    man_data       = 32'h1234_5678;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_9000_0007;
    d_ready        = 1'b1;
    step();
    man_ok         = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (f_valid !== 1'b0 || ireq_valid !== 1'b0) begin errors++; $display("FAIL redir_ok_drop: got f_valid=%b ireq_valid=%b expected 0 0", f_valid, ireq_valid); end
    step();
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h0000_0000_9000_0004) begin errors++; $display("FAIL redir_ok_next_request: got valid=%b addr=%h expected valid=1 addr=0000000090000004", ireq_valid, ireq_addr); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL redir_ok_slot: got f_valid=%b expected 0", f_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    checks++; if (ireq_valid !== 1'b0) begin errors++; $display("FAIL wrap_no_request_on_redirect: got ireq_valid=%b expected 0", ireq_valid); end
    step();
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_request: got valid=%b addr=%h expected valid=1 addr=fffffffffffffffc", ireq_valid, ireq_addr); end
    man_ok   = 1'b1;
    man_data = 32'hA5A5_A5A5;
    step();
    man_ok = 1'b0;
    checks++; if (f_valid !== 1'b1 || f_pc !== 64'hFFFF_FFFF_FFFF_FFFC || f_raw_instr !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wrap_slot: got v=%b pc=%h raw=%h expected v=1 pc=fffffffffffffffc raw=a5a5a5a5", f_valid, f_pc, f_raw_instr); end
    step();
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'd0) begin errors++; $display("FAIL wrap_next_request: got valid=%b addr=%h expected valid=1 addr=0", ireq_valid, ireq_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    d_ready = 1'b0;
    step();
    man_ok   = 1'b1;
    man_data = 32'h1111_2222;
    step();
    man_ok  = 1'b0;
    d_ready = 1'b1;
    step();
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== PC_RST + 64'd4 || f_pc !== PC_RST) begin errors++; $display("FAIL areset_setup: got valid=%b addr=%h f_pc=%h expected valid=1 addr=%h f_pc=%h", ireq_valid, ireq_addr, f_pc, PC_RST + 64'd4, PC_RST); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (ireq_valid !== 1'b0 || ireq_addr !== 64'd0) begin errors++; $display("FAIL areset_req_clear: got valid=%b addr=%h expected valid=0 addr=0", ireq_valid, ireq_addr); end
    checks++; if (f_valid !== 1'b0 || f_pc !== 64'd0 || f_raw_instr !== 32'd0) begin errors++; $display("FAIL areset_slot_clear: got v=%b pc=%h raw=%h expected all 0", f_valid, f_pc, f_raw_instr); end
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    man_ok   = 1'b1;
    man_data = 32'hBAD0_BAD0;
    step();
    man_ok = 1'b0;
    checks++; if (ireq_valid !== 1'b1 || ireq_addr !== PC_RST) begin errors++; $display("FAIL areset_first_request: got valid=%b addr=%h expected valid=1 addr=%h", ireq_valid, ireq_addr, PC_RST); end
    step();
    checks++; if (f_valid !== 1'b0 || ireq_valid !== 1'b1) begin errors++; $display("FAIL areset_stray_response: got f_valid=%b ireq_valid=%b expected 0 1", f_valid, ireq_valid); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int n;
    int guard;
    bit stalled;
    do_reset();
    mem_lat = 1;
    mem_en  = 1'b1;
    n       = 0;
    guard   = 0;
    stalled = 1'b0;
    while (n < 10 && guard < 200) begin
      if (f_valid && !stalled) begin
        d_ready = 1'b0;
        repeat (4) step();
        d_ready = 1'b1;
        stalled = 1'b1;
      end
      if (f_valid) n++;
      step();
      guard++;
    end
    checks++; if (n != 10) begin errors++; $display("FAIL perf_timeout: got %0d transfers expected 10 within 200 cycles", n); end
    checks++; if (perf_fetched !== 64'd10) begin errors++; $display("FAIL perf_fetched: got %0d expected 10", perf_fetched); end
    checks++; if (perf_stall !== 64'd4) begin errors++; $display("FAIL perf_stall: got %0d expected 4", perf_stall); end
    mem_en = 1'b0;
  endtask
`endif

  initial begin
    reset_n        = 1'b0;
    d_ready        = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    test_reset();
    test_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_dataok();
    test_wrap();
    test_async_reset();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
